// File: rtl/tile_zrange_pkg.sv
// ---------------------------------------------------------------------------
// tile_zrange_pkg
//
// Purpose: shared types, default sizes and depth-compare helpers for the
// tile Z-range metadata builder.
//
// Contents:
//   DEFAULT_WIDTH      default depth value width (matches depth-bounds unit)
//   DEFAULT_TILE_BITS  default tile index width
//   state_t            builder FSM state encoding
//   z_min / z_max      unsigned min/max helpers
//
// The compare helpers work on a 32-bit container so that one pair of
// functions serves any depth width up to 32 bits. Callers zero-extend their
// operands and truncate the result back to their own width. Because the
// operands are zero-extended, the unsigned ordering is preserved exactly.
// ---------------------------------------------------------------------------
package tile_zrange_pkg;

  localparam int DEFAULT_WIDTH     = 24;
  localparam int DEFAULT_TILE_BITS = 12;

  // Container width for the compare helpers; the depth width must not exceed it.
  localparam int ZCMP_WIDTH = 32;

  typedef logic [ZCMP_WIDTH-1:0] zcmp_t;

  // RD_REQ / RD_WAIT are only reachable when the merge option is built in.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    EMIT    = 3'd4
  } state_t;

  // Returns the smaller value. On a tie the current value is returned, so a
  // register that is fed its own value back stays unchanged.
  function automatic zcmp_t z_min(input zcmp_t cur, input zcmp_t cand);
    return (cand < cur) ? cand : cur;
  endfunction

  // Returns the larger value. On a tie the current value is returned.
  function automatic zcmp_t z_max(input zcmp_t cur, input zcmp_t cand);
    return (cand > cur) ? cand : cur;
  endfunction

endpackage

// File: rtl/zrange_accum.sv
// ---------------------------------------------------------------------------
// zrange_accum
//
// Purpose: a zmin/zmax register pair that tracks the depth range of the
// tile segment that is currently open.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset (clears both to 0)
//   init                  load both registers with z (first fragment of a segment)
//   update                widen the range with z (further fragments)
//   merge                 widen the range with merge_zmin / merge_zmax
//   z                     fragment depth value
//   merge_zmin/merge_zmax existing tile range read back from the metadata store
//   zmin, zmax            current range
//
// Priority is init > update > merge. The controlling FSM never asserts more
// than one of these at a time; the fixed priority only keeps the behaviour
// defined if that ever changes.
// ---------------------------------------------------------------------------
module zrange_accum
  import tile_zrange_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             update,
  input  logic             merge,
  input  logic [WIDTH-1:0] z,
  input  logic [WIDTH-1:0] merge_zmin,
  input  logic [WIDTH-1:0] merge_zmax,
  output logic [WIDTH-1:0] zmin,
  output logic [WIDTH-1:0] zmax
);

  // Range registers. Min and max are always updated from the same source,
  // so zmin <= zmax holds once init has loaded them from a single value.
  always_ff @(posedge clk) begin
    if (rst) begin
      zmin <= '0;
      zmax <= '0;
    end else if (init) begin
      zmin <= z;
      zmax <= z;
    end else if (update) begin
      zmin <= WIDTH'(z_min(zcmp_t'(zmin), zcmp_t'(z)));
      zmax <= WIDTH'(z_max(zcmp_t'(zmax), zcmp_t'(z)));
    end else if (merge) begin
      zmin <= WIDTH'(z_min(zcmp_t'(zmin), zcmp_t'(merge_zmin)));
      zmax <= WIDTH'(z_max(zcmp_t'(zmax), zcmp_t'(merge_zmax)));
    end
  end

endmodule

// File: rtl/tile_zrange_builder.sv
// ---------------------------------------------------------------------------
// tile_zrange_builder
//
// Purpose: this block consumes the stream of depth values written by
// fragments that pass the depth test. It tracks the min/max depth of each
// contiguous run of fragments for the same tile (a segment). When a segment
// closes, it issues one metadata write (tile, zmin, zmax) for the depth-bounds
// unit.
//
// Build option:
//   TILE_ZRANGE_MERGE_EN  When defined, the tile's existing metadata is read
//                         back before the write, and the written range is the
//                         union of that metadata and the segment's range. A
//                         partially covered tile therefore keeps a
//                         conservative range. When undefined, the read states
//                         are absent, meta_rd_en is 0, and the segment's
//                         range is written as-is.
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   frag_valid/frag_ready         fragment handshake
//   frag_tile, frag_z, frag_last  fragment tile, depth value, end of segment
//   flush                         one-cycle pulse that closes the open segment
//   meta_rd_en, meta_rd_tile      metadata read strobe and tile (merge build)
//   meta_rd_zmin/meta_rd_zmax     old tile range, valid one cycle after meta_rd_en
//   meta_wr_valid/meta_wr_ready   metadata write handshake
//   meta_wr_tile/zmin/zmax        metadata write payload
//   busy                          high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module tile_zrange_builder
  import tile_zrange_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int TILE_BITS = DEFAULT_TILE_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frag_valid,
  output logic                 frag_ready,
  input  logic [TILE_BITS-1:0] frag_tile,
  input  logic [WIDTH-1:0]     frag_z,
  input  logic                 frag_last,
  input  logic                 flush,
  output logic                 meta_rd_en,
  output logic [TILE_BITS-1:0] meta_rd_tile,
  input  logic [WIDTH-1:0]     meta_rd_zmin,
  input  logic [WIDTH-1:0]     meta_rd_zmax,
  output logic                 meta_wr_valid,
  input  logic                 meta_wr_ready,
  output logic [TILE_BITS-1:0] meta_wr_tile,
  output logic [WIDTH-1:0]     meta_wr_zmin,
  output logic [WIDTH-1:0]     meta_wr_zmax,
  output logic                 busy
);

`ifdef TILE_ZRANGE_MERGE_EN
  localparam state_t CLOSE_STATE = RD_REQ;
`else
  localparam state_t CLOSE_STATE = EMIT;
`endif

  state_t               state;
  state_t               state_next;
  logic [TILE_BITS-1:0] cur_tile;
  logic                 tile_match;
  logic                 ready_raw;
  logic                 accept;
  logic                 acc_init;
  logic                 acc_update;
  logic                 acc_merge;
  logic [WIDTH-1:0]     zmin;
  logic [WIDTH-1:0]     zmax;

  assign tile_match = (frag_tile == cur_tile);

  // State register. A reset discards any open or closing segment, so no
  // write is issued for it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Tile of the open segment. It is captured on the first fragment of the
  // segment and held through the read and write phases.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_tile <= '0;
    end else if (acc_init) begin
      cur_tile <= frag_tile;
    end
  end

  // Next-state and accumulator control.
  // In ACCUM, several close conditions can be true in the same cycle:
  //   1. an accepted last fragment
  //   2. flush
  //   3. a fragment for another tile
  // They are listed in priority order. All three lead to the same state.
  // A fragment for another tile is never accepted here. It stays on the
  // input and starts the next segment once the FSM is back in IDLE.
  // frag_ready depends only on the state and the tile compare. It never
  // depends on meta_wr_ready.
  always_comb begin
    state_next = state;
    ready_raw  = 1'b0;
    accept     = 1'b0;
    acc_init   = 1'b0;
    acc_update = 1'b0;
    acc_merge  = 1'b0;
    case (state)
      IDLE: begin
        ready_raw = 1'b1;
        accept    = frag_valid;
        acc_init  = accept;
        if (accept) begin
          state_next = frag_last ? CLOSE_STATE : ACCUM;
        end
      end
      ACCUM: begin
        ready_raw  = tile_match;
        accept     = frag_valid && tile_match;
        acc_update = accept;
        if (accept && frag_last) begin
          state_next = CLOSE_STATE;
        end else if (flush) begin
          state_next = CLOSE_STATE;
        end else if (frag_valid && !tile_match) begin
          state_next = CLOSE_STATE;
        end
      end
`ifdef TILE_ZRANGE_MERGE_EN
      RD_REQ: begin
        state_next = RD_WAIT;
      end
      RD_WAIT: begin
        acc_merge  = 1'b1;
        state_next = EMIT;
      end
`endif
      EMIT: begin
        if (meta_wr_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The read data ports always feed the merge inputs. In the build without
  // merge, acc_merge stays 0, so those inputs never affect the range.
  zrange_accum #(
    .WIDTH (WIDTH)
  ) u_accum (
    .clk        (clk),
    .rst        (rst),
    .init       (acc_init),
    .update     (acc_update),
    .merge      (acc_merge),
    .z          (frag_z),
    .merge_zmin (meta_rd_zmin),
    .merge_zmax (meta_rd_zmax),
    .zmin       (zmin),
    .zmax       (zmax)
  );

  // Control outputs are forced low while rst is high. The state register
  // still holds its old value during that cycle, but downstream blocks must
  // not see a handshake.
  assign frag_ready    = ready_raw && !rst;
  assign busy          = (state != IDLE) && !rst;
  assign meta_wr_valid = (state == EMIT) && !rst;

`ifdef TILE_ZRANGE_MERGE_EN
  assign meta_rd_en = (state == RD_REQ) && !rst;
`else
  assign meta_rd_en = 1'b0;
`endif

  // The payload comes straight from registers. It therefore stays stable for
  // as long as EMIT waits on meta_wr_ready.
  assign meta_rd_tile = cur_tile;
  assign meta_wr_tile = cur_tile;
  assign meta_wr_zmin = zmin;
  assign meta_wr_zmax = zmax;

endmodule

// File: tb/tb_tile_zrange_builder.sv
// ---------------------------------------------------------------------------
// tb_tile_zrange_builder
//
// Directed bench for tile_zrange_builder. Expected ranges and latencies
// depend on whether TILE_ZRANGE_MERGE_EN is defined, and the bench follows
// whichever build it is compiled with. Tests that are not about merging drive
// a neutral old range (min = all ones, max = 0), so the result is identical
// in both builds.
// ---------------------------------------------------------------------------
module tb_tile_zrange_builder;

  localparam int WIDTH     = 24;
  localparam int TILE_BITS = 12;

`ifdef TILE_ZRANGE_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  localparam int EXP_LAT = MERGE ? 3 : 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 frag_valid;
  logic                 frag_ready;
  logic [TILE_BITS-1:0] frag_tile;
  logic [WIDTH-1:0]     frag_z;
  logic                 frag_last;
  logic                 flush;
  logic                 meta_rd_en;
  logic [TILE_BITS-1:0] meta_rd_tile;
  logic [WIDTH-1:0]     meta_rd_zmin;
  logic [WIDTH-1:0]     meta_rd_zmax;
  logic                 meta_wr_valid;
  logic                 meta_wr_ready;
  logic [TILE_BITS-1:0] meta_wr_tile;
  logic [WIDTH-1:0]     meta_wr_zmin;
  logic [WIDTH-1:0]     meta_wr_zmax;
  logic                 busy;

  int vectors     = 0;
  int miscompares = 0;
  int wr_count    = 0;

  always #5 clk = ~clk;

  tile_zrange_builder #(
    .WIDTH     (WIDTH),
    .TILE_BITS (TILE_BITS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frag_valid    (frag_valid),
    .frag_ready    (frag_ready),
    .frag_tile     (frag_tile),
    .frag_z        (frag_z),
    .frag_last     (frag_last),
    .flush         (flush),
    .meta_rd_en    (meta_rd_en),
    .meta_rd_tile  (meta_rd_tile),
    .meta_rd_zmin  (meta_rd_zmin),
    .meta_rd_zmax  (meta_rd_zmax),
    .meta_wr_valid (meta_wr_valid),
    .meta_wr_ready (meta_wr_ready),
    .meta_wr_tile  (meta_wr_tile),
    .meta_wr_zmin  (meta_wr_zmin),
    .meta_wr_zmax  (meta_wr_zmax),
    .busy          (busy)
  );

  // Counts completed metadata writes (valid && ready at a rising edge).
  always @(posedge clk) begin
    if (meta_wr_valid && meta_wr_ready) wr_count <= wr_count + 1;
  end

  // Guards against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Call this one cycle after the closing edge. It steps until meta_wr_valid
  // is seen, or until the bound runs out. lat=1 means valid was already high
  // on the cycle right after the close.
  task automatic wait_emit(output int lat, output bit rd_seen);
    lat = 1;
    rd_seen = 1'b0;
    while (!meta_wr_valid && lat < 20) begin
      if (meta_rd_en) rd_seen = 1'b1;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; frag_valid = 1'b1; frag_tile = 12'h0AA; frag_z = 24'h123; frag_last = 1'b0;
    flush = 1'b0; meta_wr_ready = 1'b1; meta_rd_zmin = '1; meta_rd_zmax = '0;
    tick(); tick();
    vectors++; if (frag_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_frag_ready: got %0h expected 0", frag_ready); end
    vectors++; if (meta_wr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_wr_valid: got %0h expected 0", meta_wr_valid); end
    vectors++; if (meta_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rd_en: got %0h expected 0", meta_rd_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %0h expected 0", busy); end
    vectors++; if (meta_wr_tile !== 12'h0) begin miscompares++; $display("[TB] FAIL reset_wr_tile: got %0h expected 0", meta_wr_tile); end
    vectors++; if (meta_wr_zmin !== 24'h0) begin miscompares++; $display("[TB] FAIL reset_wr_zmin: got %0h expected 0", meta_wr_zmin); end
    vectors++; if (meta_wr_zmax !== 24'h0) begin miscompares++; $display("[TB] FAIL reset_wr_zmax: got %0h expected 0", meta_wr_zmax); end
    vectors++; if (meta_rd_tile !== 12'h0) begin miscompares++; $display("[TB] FAIL reset_rd_tile: got %0h expected 0", meta_rd_tile); end
    rst = 1'b0; frag_valid = 1'b0;
    tick();
    vectors++; if (frag_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL idle_frag_ready: got %0h expected 1", frag_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy: got %0h expected 0", busy); end
  endtask

  task automatic test_basic_segment;
    int lat; bit rd_seen; int wc0;
    wc0 = wr_count;
    meta_rd_zmin = '1; meta_rd_zmax = '0; meta_wr_ready = 1'b1;
    frag_valid = 1'b1; frag_tile = 12'd5; frag_z = 24'h100; frag_last = 1'b0;
    #1;
    vectors++; if (frag_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_ready0: got %0h expected 1", frag_ready); end
    tick();
    frag_z = 24'h050;
    #1;
    vectors++; if (frag_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_ready1: got %0h expected 1", frag_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_busy: got %0h expected 1", busy); end
    tick();
    frag_z = 24'h300; frag_last = 1'b1;
    #1;
    vectors++; if (frag_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_ready2: got %0h expected 1", frag_ready); end
    tick();
    frag_valid = 1'b0; frag_last = 1'b0;
    wait_emit(lat, rd_seen);
    vectors++; if (lat !== EXP_LAT) begin miscompares++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, EXP_LAT); end
    vectors++; if (rd_seen !== MERGE) begin miscompares++; $display("[TB] FAIL basic_rd_en: got %0h expected %0h", rd_seen, MERGE); end
    vectors++; if (meta_wr_tile !== 12'd5) begin miscompares++; $display("[TB] FAIL basic_tile: got %0h expected 5", meta_wr_tile); end
    vectors++; if (meta_wr_zmin !== 24'h050) begin miscompares++; $display("[TB] FAIL basic_zmin: got %0h expected 50", meta_wr_zmin); end
    vectors++; if (meta_wr_zmax !== 24'h300) begin miscompares++; $display("[TB] FAIL basic_zmax: got %0h expected 300", meta_wr_zmax); end
    vectors++; if (frag_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_emit_ready: got %0h expected 0", frag_ready); end
    tick();
    vectors++; if (meta_wr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_valid_drop: got %0h expected 0", meta_wr_valid); end
    vectors++; if (wr_count !== wc0 + 1) begin miscompares++; $display("[TB] FAIL basic_write_count: got %0d expected %0d", wr_count, wc0 + 1); end
  endtask

  task automatic test_merge;
    int lat; bit rd_seen; logic [WIDTH-1:0] exp_zmin;
    exp_zmin = MERGE ? 24'h200 : 24'h400;
    meta_rd_zmin = 24'h200; meta_rd_zmax = 24'h450; meta_wr_ready = 1'b1;
    frag_valid = 1'b1; frag_tile = 12'd7; frag_z = 24'h400; frag_last = 1'b0;
    tick();
    frag_z = 24'h500; frag_last = 1'b1;
    tick();
    frag_valid = 1'b0; frag_last = 1'b0;
    vectors++; if (meta_rd_tile !== 12'd7) begin miscompares++; $display("[TB] FAIL merge_rd_tile: got %0h expected 7", meta_rd_tile); end
    wait_emit(lat, rd_seen);
    vectors++; if (lat !== EXP_LAT) begin miscompares++; $display("[TB] FAIL merge_latency: got %0d expected %0d", lat, EXP_LAT); end
    vectors++; if (rd_seen !== MERGE) begin miscompares++; $display("[TB] FAIL merge_rd_en: got %0h expected %0h", rd_seen, MERGE); end
    vectors++; if (meta_wr_tile !== 12'd7) begin miscompares++; $display("[TB] FAIL merge_tile: got %0h expected 7", meta_wr_tile); end
    vectors++; if (meta_wr_zmin !== exp_zmin) begin miscompares++; $display("[TB] FAIL merge_zmin: got %0h expected %0h", meta_wr_zmin, exp_zmin); end
    vectors++; if (meta_wr_zmax !== 24'h500) begin miscompares++; $display("[TB] FAIL merge_zmax: got %0h expected 500", meta_wr_zmax); end
    tick();
    meta_rd_zmin = '1; meta_rd_zmax = '0;
  endtask

  task automatic test_tile_switch;
    int lat; bit rd_seen; int wc0;
    wc0 = wr_count;
    meta_wr_ready = 1'b1;
    frag_valid = 1'b1; frag_tile = 12'd3; frag_z = 24'h10; frag_last = 1'b0;
    tick();
    frag_tile = 12'd4; frag_z = 24'h20;
    #1;
    vectors++; if (frag_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL switch_hold_ready: got %0h expected 0", frag_ready); end
    tick();
    wait_emit(lat, rd_seen);
    vectors++; if (lat !== EXP_LAT) begin miscompares++; $display("[TB] FAIL switch_latency: got %0d expected %0d", lat, EXP_LAT); end
    vectors++; if (meta_wr_tile !== 12'd3) begin miscompares++; $display("[TB] FAIL switch_tile: got %0h expected 3", meta_wr_tile); end
    vectors++; if (meta_wr_zmin !== 24'h10) begin miscompares++; $display("[TB] FAIL switch_zmin: got %0h expected 10", meta_wr_zmin); end
    vectors++; if (meta_wr_zmax !== 24'h10) begin miscompares++; $display("[TB] FAIL switch_zmax: got %0h expected 10", meta_wr_zmax); end
    vectors++; if (frag_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL switch_emit_ready: got %0h expected 0", frag_ready); end
    tick();
    vectors++; if (frag_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL switch_next_ready: got %0h expected 1", frag_ready); end
    tick();
    frag_valid = 1'b0; flush = 1'b1;
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL switch_accum_busy: got %0h expected 1", busy); end
    tick();
    flush = 1'b0;
    wait_emit(lat, rd_seen);
    vectors++; if (meta_wr_tile !== 12'd4) begin miscompares++; $display("[TB] FAIL switch_tile4: got %0h expected 4", meta_wr_tile); end
    vectors++; if (meta_wr_zmin !== 24'h20 || meta_wr_zmax !== 24'h20) begin miscompares++; $display("[TB] FAIL switch_range4: got %0h..%0h expected 20..20", meta_wr_zmin, meta_wr_zmax); end
    tick();
    vectors++; if (wr_count !== wc0 + 2) begin miscompares++; $display("[TB] FAIL switch_write_count: got %0d expected %0d", wr_count, wc0 + 2); end
  endtask

  task automatic test_backpressure;
    int lat; bit rd_seen; int wc0;
    wc0 = wr_count;
    meta_wr_ready = 1'b0;
    frag_valid = 1'b1; frag_tile = 12'h0AB; frag_z = 24'h123; frag_last = 1'b1;
    tick();
    frag_valid = 1'b0; frag_last = 1'b0;
    wait_emit(lat, rd_seen);
    for (int i = 0; i < 5; i++) begin
      vectors++; if (meta_wr_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL bp_valid[%0d]: got %0h expected 1", i, meta_wr_valid); end
      vectors++; if (meta_wr_tile !== 12'h0AB || meta_wr_zmin !== 24'h123 || meta_wr_zmax !== 24'h123) begin
        miscompares++; $display("[TB] FAIL bp_payload[%0d]: got %0h %0h..%0h expected ab 123..123", i, meta_wr_tile, meta_wr_zmin, meta_wr_zmax);
      end
      vectors++; if (frag_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_ready[%0d]: got %0h expected 0", i, frag_ready); end
      tick();
    end
    vectors++; if (wr_count !== wc0) begin miscompares++; $display("[TB] FAIL bp_no_write: got %0d expected %0d", wr_count, wc0); end
    meta_wr_ready = 1'b1;
    tick();
    vectors++; if (wr_count !== wc0 + 1) begin miscompares++; $display("[TB] FAIL bp_single_write: got %0d expected %0d", wr_count, wc0 + 1); end
    vectors++; if (meta_wr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL bp_valid_drop: got %0h expected 0", meta_wr_valid); end
  endtask

  task automatic test_flush;
    int lat; bit rd_seen; int wc0;
    meta_wr_ready = 1'b1;
    frag_valid = 1'b1; frag_tile = 12'd9; frag_z = 24'hFFFFFF; frag_last = 1'b0;
    tick();
    frag_z = 24'h000000;
    tick();
    frag_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_emit(lat, rd_seen);
    vectors++; if (lat !== EXP_LAT) begin miscompares++; $display("[TB] FAIL flush_latency: got %0d expected %0d", lat, EXP_LAT); end
    vectors++; if (meta_wr_tile !== 12'd9) begin miscompares++; $display("[TB] FAIL flush_tile: got %0h expected 9", meta_wr_tile); end
    vectors++; if (meta_wr_zmin !== 24'h000000) begin miscompares++; $display("[TB] FAIL flush_zmin: got %0h expected 0", meta_wr_zmin); end
    vectors++; if (meta_wr_zmax !== 24'hFFFFFF) begin miscompares++; $display("[TB] FAIL flush_zmax: got %0h expected ffffff", meta_wr_zmax); end
    tick();
    wc0 = wr_count;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (meta_wr_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_flush[%0d]: got valid %0h busy %0h expected 0 0", i, meta_wr_valid, busy); end
      tick();
    end
    vectors++; if (wr_count !== wc0) begin miscompares++; $display("[TB] FAIL idle_flush_count: got %0d expected %0d", wr_count, wc0); end
  endtask

  task automatic test_reset_mid;
    int lat; bit rd_seen; int wc0;
    wc0 = wr_count;
    meta_wr_ready = 1'b1;
    frag_valid = 1'b1; frag_tile = 12'h011; frag_z = 24'h55; frag_last = 1'b0;
    tick();
    frag_valid = 1'b0; rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || frag_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_accum_gate: got busy %0h ready %0h expected 0 0", busy, frag_ready); end
    tick();
    vectors++; if (meta_wr_tile !== 12'h0 || meta_wr_zmin !== 24'h0 || meta_wr_zmax !== 24'h0) begin
      miscompares++; $display("[TB] FAIL rst_accum_payload: got %0h %0h..%0h expected 0 0..0", meta_wr_tile, meta_wr_zmin, meta_wr_zmax);
    end
    rst = 1'b0;
    tick(); tick(); tick();
    vectors++; if (meta_wr_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_accum_idle: got valid %0h busy %0h expected 0 0", meta_wr_valid, busy); end
    vectors++; if (wr_count !== wc0) begin miscompares++; $display("[TB] FAIL rst_accum_count: got %0d expected %0d", wr_count, wc0); end
    meta_wr_ready = 1'b0;
    frag_valid = 1'b1; frag_tile = 12'h022; frag_z = 24'h66; frag_last = 1'b1;
    tick();
    frag_valid = 1'b0; frag_last = 1'b0;
    wait_emit(lat, rd_seen);
    vectors++; if (meta_wr_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_emit_reached: got %0h expected 1", meta_wr_valid); end
    rst = 1'b1;
    tick();
    vectors++; if (meta_wr_valid !== 1'b0 || meta_rd_en !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_emit_valid: got %0h rd %0h expected 0 0", meta_wr_valid, meta_rd_en); end
    vectors++; if (meta_wr_tile !== 12'h0 || meta_wr_zmin !== 24'h0 || meta_wr_zmax !== 24'h0) begin
      miscompares++; $display("[TB] FAIL rst_emit_payload: got %0h %0h..%0h expected 0 0..0", meta_wr_tile, meta_wr_zmin, meta_wr_zmax);
    end
    rst = 1'b0; meta_wr_ready = 1'b1;
    tick(); tick();
    vectors++; if (meta_wr_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_emit_after: got %0h expected 0", meta_wr_valid); end
    vectors++; if (wr_count !== wc0) begin miscompares++; $display("[TB] FAIL rst_emit_count: got %0d expected %0d", wr_count, wc0); end
  endtask

  initial begin
    $display("[TB] tile_zrange_builder bench, merge build = %0d", MERGE);
    test_reset();
    test_basic_segment();
    test_merge();
    test_tile_switch();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
